dcache_victim_buffer: RTL and testbench
=======================================

# dcache_victim_buffer

Parametrised, fully associative victim buffer that sits between the dcache array and the memory arbiter. It replaces the fixed two-port, clean-drop victim FIFO with several additions:
- configurable depth and read-port count;
- oldest-first ordering that stays compacted after any entry is removed;
- store-hit merging with byte masks;
- promotion of lines back into the dcache;
- a one-entry writeback register with a valid/ready handshake to the arbiter, so dirty displacements are never lost.

## Interface

Parameters:
- DEPTH, 4: number of victim entries (≥2).
- NUM_RD, 2: number of parallel lookup ports.
- TAG_W, `DTAG_BITS: line tag width.
- DATA_W, `MEM_BLOCK_BITS: line data width (multiple of 8).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- insert_valid  in  1  line evicted from the dcache.
- insert_tag  in  TAG_W  tag of the evicted line.
- insert_data  in  DATA_W  data of the evicted line.
- insert_dirty  in  1  dirty bit of the evicted line.
- insert_ready  out  1  buffer can accept the insert this cycle.
- rd_valid  in  NUM_RD  lookup enables.
- rd_tag  in  NUM_RD×TAG_W  lookup tags.
- rd_hit  out  NUM_RD  lookup hit.
- rd_data  out  NUM_RD×DATA_W  hit data, zero on miss.
- store_valid  in  1  store write.
- store_tag  in  TAG_W  store target tag.
- store_data  in  DATA_W  store data.
- store_mask  in  DATA_W/8  byte enables.
- promote_valid  in  1  dcache is pulling a line back.
- promote_tag  in  TAG_W  tag being promoted.
- promote_hit  out  1  promoted tag was present.
- promote_data  out  DATA_W  data of the promoted line.
- promote_dirty  out  1  dirty bit of the promoted line.
- wb_valid  out  1  writeback register occupied.
- wb_tag  out  TAG_W  writeback tag.
- wb_data  out  DATA_W  writeback data.
- wb_ready  in  1  arbiter accepts the writeback.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation

- **Storage.** Entries 0..count-1 are valid and age-ordered; entry 0 is the oldest. Each entry holds {tag, data, dirty}.
- **Lookup.** Combinational on all ports. A lookup hits on a valid entry or on the writeback register when wb_valid=1. The entry wins over the writeback register (both never hold the same tag by protocol).
- **Store.** When store_tag matches an entry, the masked bytes are merged into that entry and its dirty bit is set. When it matches the writeback register instead, the merge goes into wb_data. A store that matches nothing has no effect.
- **Promote.** On a match, promote_hit=1 and promote_data/promote_dirty come from the entry, with any same-cycle store to that tag already merged (dirty forced to 1 in that case). The entry is removed and younger entries shift down by one. A promote never removes the writeback register.
- **Insert.** The new line is appended at index count, after any same-cycle promote removal.
- **Insert when full.** If the buffer is full and no promote hits, the oldest entry is displaced:
  - clean: the line is dropped;
  - dirty: the line moves into the writeback register.
- **insert_ready=0** only when all of the following hold: the buffer is full, no promote hits, entry 0 is dirty, wb_valid=1, and wb_ready=0.
- **Writeback state machine.**
  - WB_IDLE → WB_PEND when the writeback register is loaded.
  - WB_PEND → WB_IDLE on wb_ready.
  - In WB_PEND, an accept and a new load in the same cycle keep the state at WB_PEND, holding the new line.
  - wb_tag/wb_data are stable while wb_valid=1 and wb_ready=0, except for store merges.
- **Protocol assertions.**
  - An insert tag never matches a resident entry or the writeback register.
  - insert_valid is held while insert_ready=0.

## Timing

- Lookup, promote outputs and insert_ready are combinational in the same cycle.
- Insert, store, promote removal and writeback loads become visible on the next cycle.
- A lookup in the same cycle as an insert of that tag misses.
- A lookup in the same cycle as a store returns the pre-store data.
- Reset values: all entries invalid, count=0, wb_valid=0, wb_tag=0, wb_data=0, insert_ready=1, rd_hit=0, rd_data=0, promote_hit=0. The state machine resets to WB_IDLE.
- Reset mid-handshake discards the pending writeback.

## Configuration

- **DCACHE_VB_EAGER_DRAIN_EN defined:** in any cycle where all of the following hold, the oldest dirty entry is copied into the writeback register and its dirty bit is cleared; the entry stays resident:
  - wb_valid=0, or wb_ready=1;
  - no insert displacement occurs;
  - no store targets that entry.
- **Undefined:** writebacks occur only on dirty displacement.

## Test plan

- **Reset and fill.** Reset, then insert clean tags 0x10..0x13 → count=4, insert_ready=1, wb_valid=0; rd_tag=0x12 gives rd_hit=1 with the inserted data.
- **Dirty displacement.** Full buffer with entry 0 (tag 0x10) dirty; insert 0x14 → next cycle wb_valid=1, wb_tag=0x10, count=4. Holding wb_ready=0 keeps wb_valid=1 and lookup of 0x10 still hits.
- **Stall on busy writeback.** Writeback register busy, wb_ready=0, entry 0 dirty, buffer full; insert → insert_ready=0 and the state is unchanged. Raising wb_ready → insert_ready=1 and the insert completes that cycle.
- **Promote compaction.** Promote 0x11 from {0x10, 0x11, 0x12} together with a same-cycle insert of 0x15 → promote_hit=1; next cycle the order is {0x10, 0x12, 0x15} and count=3.
- **Store merge, then promote.** Store mask 0x01, data 0xAB to 0x12, then promote 0x12 → promote_dirty=1 and byte 0 of promote_data is 0xAB. Repeating store and promote in the same cycle gives the same result.
- **Eager drain (macro defined).** Single dirty entry, idle inputs → wb_valid=1 on the next cycle and the entry stays resident with dirty=0. With the macro undefined → wb_valid stays 0.

Source files
------------

// File: rtl/dcache_victim_buffer.sv
// Fully associative, age-ordered victim buffer with store merge, promotion and a one-entry
// writeback register. Optional eager drain of dirty entries: DCACHE_VB_EAGER_DRAIN_EN.
`ifndef DTAG_BITS
`define DTAG_BITS 16
`endif
`ifndef MEM_BLOCK_BITS
`define MEM_BLOCK_BITS 64
`endif

module dcache_victim_buffer #(
  parameter int DEPTH  = 4,
  parameter int NUM_RD = 2,
  parameter int TAG_W  = `DTAG_BITS,
  parameter int DATA_W = `MEM_BLOCK_BITS,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int NB    = DATA_W / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     insert_valid,
  input  logic [TAG_W-1:0]         insert_tag,
  input  logic [DATA_W-1:0]        insert_data,
  input  logic                     insert_dirty,
  output logic                     insert_ready,
  input  logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_RD*TAG_W-1:0]  rd_tag,
  output logic [NUM_RD-1:0]        rd_hit,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     store_valid,
  input  logic [TAG_W-1:0]         store_tag,
  input  logic [DATA_W-1:0]        store_data,
  input  logic [NB-1:0]            store_mask,
  input  logic                     promote_valid,
  input  logic [TAG_W-1:0]         promote_tag,
  output logic                     promote_hit,
  output logic [DATA_W-1:0]        promote_data,
  output logic                     promote_dirty,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_ready,
  output logic [CNT_W-1:0]         count
);

  typedef enum logic {WB_IDLE, WB_PEND} wb_state_e;

  wb_state_e         state_q;
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic              dirty_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [TAG_W-1:0]  tag_m   [DEPTH], tag_d   [DEPTH];
  logic [DATA_W-1:0] data_m  [DEPTH], data_d  [DEPTH];
  logic              dirty_m [DEPTH], dirty_d [DEPTH];
  logic [CNT_W-1:0]  count_d;
  logic              full, displace, st_wb_hit, wb_ld, ins_collide;
  logic [TAG_W-1:0]  wb_ld_tag;
  logic [DATA_W-1:0] wb_ld_data, wb_merged;

  assign wb_valid = (state_q == WB_PEND);
  assign wb_tag   = wb_tag_q;
  assign wb_data  = wb_data_q;
  assign count    = count_q;

  // Lookups see pre-update state: same-cycle inserts miss, same-cycle stores are not visible.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_hit[r] = 1'b0;
      rd_data[r*DATA_W +: DATA_W] = '0;
      if (rd_valid[r]) begin
        if (wb_valid && wb_tag_q == rd_tag[r*TAG_W +: TAG_W]) begin
          rd_hit[r] = 1'b1;
          rd_data[r*DATA_W +: DATA_W] = wb_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (i < int'(count_q) && tag_q[i] == rd_tag[r*TAG_W +: TAG_W]) begin
            rd_hit[r] = 1'b1;
            rd_data[r*DATA_W +: DATA_W] = data_q[i];
          end
        end
      end
    end
  end

  always_comb begin : p_next
    int cnt, cnt_n, st_idx, pr_idx, rem;
    cnt       = int'(count_q);
    full      = (cnt == DEPTH);
    tag_m     = tag_q;
    data_m    = data_q;
    dirty_m   = dirty_q;
    st_idx    = -1;
    pr_idx    = -1;
    st_wb_hit = 1'b0;
    wb_merged = wb_data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (store_valid && i < cnt && st_idx < 0 && tag_q[i] == store_tag) begin
        st_idx     = i;
        dirty_m[i] = 1'b1;
        for (int b = 0; b < NB; b++)
          if (store_mask[b]) data_m[i][8*b +: 8] = store_data[8*b +: 8];
      end
    end
    if (store_valid && st_idx < 0 && wb_valid && wb_tag_q == store_tag) begin
      st_wb_hit = 1'b1;
      for (int b = 0; b < NB; b++)
        if (store_mask[b]) wb_merged[8*b +: 8] = store_data[8*b +: 8];
    end
    for (int i = 0; i < DEPTH; i++)
      if (promote_valid && i < cnt && pr_idx < 0 && tag_q[i] == promote_tag) pr_idx = i;
    promote_hit   = (pr_idx >= 0);
    promote_data  = '0;
    promote_dirty = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == pr_idx) begin
        promote_data  = data_m[i];
        promote_dirty = dirty_m[i];
      end
    end
    // Entry 0 dirtiness includes a same-cycle store so a merged line is never dropped.
    insert_ready = !(full && !promote_hit && dirty_m[0] && wb_valid && !wb_ready);
    displace     = insert_valid && insert_ready && full && !promote_hit;
    wb_ld        = displace && dirty_m[0];
    wb_ld_tag    = tag_m[0];
    wb_ld_data   = data_m[0];
`ifdef DCACHE_VB_EAGER_DRAIN_EN
    begin : eager
      int dr_idx;
      dr_idx = -1;
      for (int i = 0; i < DEPTH; i++)
        if (i < cnt && dirty_q[i] && dr_idx < 0) dr_idx = i;
      if (dr_idx >= 0 && (!wb_valid || wb_ready) && !displace &&
          dr_idx != st_idx && dr_idx != pr_idx) begin
        wb_ld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (i == dr_idx) begin
            wb_ld_tag  = tag_m[i];
            wb_ld_data = data_m[i];
            dirty_m[i] = 1'b0;
          end
        end
      end
    end
`endif
    rem     = promote_hit ? pr_idx : (displace ? 0 : DEPTH);
    tag_d   = tag_m;
    data_d  = data_m;
    dirty_d = dirty_m;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i >= rem) begin
        tag_d[i]   = tag_m[i+1];
        data_d[i]  = data_m[i+1];
        dirty_d[i] = dirty_m[i+1];
      end
    end
    cnt_n = cnt - ((promote_hit || displace) ? 1 : 0);
    if (insert_valid && insert_ready) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == cnt_n) begin
          tag_d[i]   = insert_tag;
          data_d[i]  = insert_data;
          dirty_d[i] = insert_dirty;
        end
      end
      cnt_n = cnt_n + 1;
    end
    count_d = CNT_W'(cnt_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= WB_IDLE;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      dirty_q <= dirty_d;
      count_q <= count_d;
      case (state_q)
        WB_IDLE: if (wb_ld) begin
          state_q   <= WB_PEND;
          wb_tag_q  <= wb_ld_tag;
          wb_data_q <= wb_ld_data;
        end
        WB_PEND: if (wb_ld) begin
          wb_tag_q  <= wb_ld_tag;
          wb_data_q <= wb_ld_data;
        end else if (wb_ready) begin
          state_q <= WB_IDLE;
        end else if (st_wb_hit) begin
          wb_data_q <= wb_merged;
        end
      endcase
    end
  end

  always_comb begin
    ins_collide = wb_valid && (wb_tag_q == insert_tag);
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(count_q) && tag_q[i] == insert_tag) ins_collide = 1'b1;
  end

  a_insert_unique: assert property (@(posedge clock) disable iff (reset)
    insert_valid |-> !ins_collide);
  a_insert_hold: assert property (@(posedge clock) disable iff (reset)
    (insert_valid && !insert_ready) |=> insert_valid);

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Bench for dcache_victim_buffer: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the victim buffer.
module tb_dcache_victim_buffer;

  logic         clock, reset;
  logic         insert_valid, insert_dirty, insert_ready;
  logic [15:0]  insert_tag;
  logic [63:0]  insert_data;
  logic [1:0]   rd_valid, rd_hit;
  logic [31:0]  rd_tag;
  logic [127:0] rd_data;
  logic         store_valid;
  logic [15:0]  store_tag;
  logic [63:0]  store_data;
  logic [7:0]   store_mask;
  logic         promote_valid, promote_hit, promote_dirty;
  logic [15:0]  promote_tag;
  logic [63:0]  promote_data;
  logic         wb_valid, wb_ready;
  logic [15:0]  wb_tag;
  logic [63:0]  wb_data;
  logic [2:0]   count;

  int tests = 0;
  int fails = 0;

  dcache_victim_buffer #(.DEPTH(4), .NUM_RD(2), .TAG_W(16), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .insert_valid(insert_valid), .insert_tag(insert_tag), .insert_data(insert_data),
    .insert_dirty(insert_dirty), .insert_ready(insert_ready),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_hit(rd_hit), .rd_data(rd_data),
    .store_valid(store_valid), .store_tag(store_tag), .store_data(store_data),
    .store_mask(store_mask),
    .promote_valid(promote_valid), .promote_tag(promote_tag), .promote_hit(promote_hit),
    .promote_data(promote_data), .promote_dirty(promote_dirty),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: queue index 0 is the oldest line.
  typedef struct { logic [15:0] tag; logic [63:0] data; logic dirty; } ent_t;
  ent_t        mq[$];
  logic        m_wbv;
  logic [15:0] m_wbt;
  logic [63:0] m_wbd;
  logic        e_ready, e_ph, e_pdirty;
  logic [63:0] e_pd;
  logic        e_rd_hit [2];
  logic [63:0] e_rd_data [2];

  function automatic logic [63:0] dat(logic [15:0] t);
    return {4{t}};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] d, logic [63:0] s, logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) d[8*b +: 8] = s[8*b +: 8];
    return d;
  endfunction

  function automatic int mfind(logic [15:0] t);
    for (int k = 0; k < mq.size(); k++) if (mq[k].tag == t) return k;
    return -1;
  endfunction

  task automatic model_comb();
    int s, p;
    logic d0;
    logic [15:0] t;
    s = store_valid ? mfind(store_tag) : -1;
    p = promote_valid ? mfind(promote_tag) : -1;
    e_ph = (p >= 0);
    e_pd = '0;
    e_pdirty = 1'b0;
    if (p >= 0) begin
      e_pd = mq[p].data;
      e_pdirty = mq[p].dirty;
      if (s == p) begin
        e_pd = merge(e_pd, store_data, store_mask);
        e_pdirty = 1'b1;
      end
    end
    d0 = (mq.size() > 0) && (mq[0].dirty || s == 0);
    e_ready = !(mq.size() == 4 && p < 0 && d0 && m_wbv && !wb_ready);
    for (int r = 0; r < 2; r++) begin
      e_rd_hit[r] = 1'b0;
      e_rd_data[r] = '0;
      t = rd_tag[16*r +: 16];
      if (rd_valid[r]) begin
        if (mfind(t) >= 0) begin
          e_rd_hit[r] = 1'b1;
          e_rd_data[r] = mq[mfind(t)].data;
        end else if (m_wbv && m_wbt == t) begin
          e_rd_hit[r] = 1'b1;
          e_rd_data[r] = m_wbd;
        end
      end
    end
  endtask

  task automatic model_update();
    int s, p, j;
    logic full, disp, load, wb_store;
    ent_t ld, v;
    if (reset) begin
      mq.delete();
      m_wbv = 1'b0; m_wbt = '0; m_wbd = '0;
      return;
    end
    model_comb();
    s = store_valid ? mfind(store_tag) : -1;
    p = promote_valid ? mfind(promote_tag) : -1;
    full = (mq.size() == 4);
    j = -1;
    for (int k = 0; k < mq.size(); k++) if (mq[k].dirty && j < 0) j = k;
    load = 1'b0;
    ld = '{tag: '0, data: '0, dirty: 1'b0};
    if (s >= 0) begin
      mq[s].data = merge(mq[s].data, store_data, store_mask);
      mq[s].dirty = 1'b1;
    end
    wb_store = store_valid && s < 0 && m_wbv && m_wbt == store_tag;
    disp = insert_valid && e_ready && full && p < 0;
`ifdef DCACHE_VB_EAGER_DRAIN_EN
    if (!disp && (!m_wbv || wb_ready) && j >= 0 && j != s && j != p) begin
      load = 1'b1;
      ld = mq[j];
      mq[j].dirty = 1'b0;
    end
`endif
    if (p >= 0) mq.delete(p);
    if (disp) begin
      v = mq.pop_front();
      if (v.dirty) begin load = 1'b1; ld = v; end
    end
    if (insert_valid && e_ready) begin
      v.tag = insert_tag; v.data = insert_data; v.dirty = insert_dirty;
      mq.push_back(v);
    end
    if (load) begin
      m_wbv = 1'b1; m_wbt = ld.tag; m_wbd = ld.data;
    end else if (m_wbv && wb_ready) begin
      m_wbv = 1'b0;
    end else if (wb_store) begin
      m_wbd = merge(m_wbd, store_data, store_mask);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic set_idle();
    insert_valid = 1'b0; insert_tag = '0; insert_data = '0; insert_dirty = 1'b0;
    rd_valid = '0; rd_tag = '0;
    store_valid = 1'b0; store_tag = '0; store_data = '0; store_mask = '0;
    promote_valid = 1'b0; promote_tag = '0;
    wb_ready = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_insert(logic [15:0] t, logic d);
    set_idle();
    insert_valid = 1'b1; insert_tag = t; insert_data = dat(t); insert_dirty = d;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    rd_valid = 2'b11; rd_tag = '0; promote_valid = 1'b1; promote_tag = '0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d want=0", count); end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    tests++; if (wb_tag !== 16'h0 || wb_data !== 64'h0) begin fails++; $display("FAIL reset_wb_regs tag=%h data=%h want=0", wb_tag, wb_data); end
    tests++; if (insert_ready !== 1'b1) begin fails++; $display("FAIL reset_insert_ready got=%b want=1", insert_ready); end
    tests++; if (rd_hit !== 2'b00 || rd_data !== 128'h0) begin fails++; $display("FAIL reset_lookup hit=%b data=%h want=0", rd_hit, rd_data); end
    tests++; if (promote_hit !== 1'b0) begin fails++; $display("FAIL reset_promote_hit got=%b want=0", promote_hit); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int t = 16'h10; t <= 16'h13; t++) begin
      set_idle();
      insert_valid = 1'b1; insert_tag = 16'(t); insert_data = dat(16'(t));
      rd_valid = 2'b10; rd_tag[31:16] = 16'(t);
      #1;
      tests++; if (rd_hit[1] !== 1'b0) begin fails++; $display("FAIL fill_same_cycle_miss tag=%h got=%b want=0", t, rd_hit[1]); end
      tick();
    end
    set_idle(); rd_valid = 2'b01; rd_tag[15:0] = 16'h12;
    #1;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got=%0d want=4", count); end
    tests++; if (insert_ready !== 1'b1 || wb_valid !== 1'b0) begin fails++; $display("FAIL fill_ready_wb ready=%b wbv=%b want=1,0", insert_ready, wb_valid); end
    tests++; if (rd_hit[0] !== 1'b1 || rd_data[63:0] !== dat(16'h12)) begin fails++; $display("FAIL fill_lookup hit=%b data=%h want=1,%h", rd_hit[0], rd_data[63:0], dat(16'h12)); end
  endtask

  task automatic test_dirty_displace();
    apply_reset();
    for (int t = 16'h10; t <= 16'h13; t++) do_insert(16'(t), t == 16'h10);
    set_idle(); insert_valid = 1'b1; insert_tag = 16'h14; insert_data = dat(16'h14);
    #1;
    tests++; if (insert_ready !== 1'b1) begin fails++; $display("FAIL disp_ready got=%b want=1", insert_ready); end
    tick();
    set_idle(); rd_valid = 2'b01; rd_tag[15:0] = 16'h10;
    #1;
    tests++; if (wb_valid !== 1'b1 || wb_tag !== 16'h10 || wb_data !== dat(16'h10)) begin fails++; $display("FAIL disp_wb v=%b tag=%h data=%h want=1,0010", wb_valid, wb_tag, wb_data); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL disp_count got=%0d want=4", count); end
    tick();
    #1;
    tests++; if (wb_valid !== 1'b1 || rd_hit[0] !== 1'b1 || rd_data[63:0] !== dat(16'h10)) begin fails++; $display("FAIL disp_hold v=%b hit=%b data=%h want=1,1", wb_valid, rd_hit[0], rd_data[63:0]); end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    set_idle(); store_valid = 1'b1; store_tag = 16'h11; store_data = 64'hAAAA_BBBB_CCCC_DDDD; store_mask = 8'h0F;
    tick();
    set_idle(); insert_valid = 1'b1; insert_tag = 16'h15; insert_data = dat(16'h15);
    rd_valid = 2'b10; rd_tag[31:16] = 16'h15;
    #1;
    tests++; if (insert_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got=%b want=0", insert_ready); end
    tick();
    #1;
    tests++; if (count !== 3'd4 || wb_tag !== 16'h10 || wb_valid !== 1'b1 || rd_hit[1] !== 1'b0) begin fails++; $display("FAIL stall_hold cnt=%0d tag=%h v=%b hit=%b want 4,0010,1,0", count, wb_tag, wb_valid, rd_hit[1]); end
    wb_ready = 1'b1;
    #1;
    tests++; if (insert_ready !== 1'b1) begin fails++; $display("FAIL stall_release got=%b want=1", insert_ready); end
    tick();
    set_idle(); rd_valid = 2'b01; rd_tag[15:0] = 16'h15;
    exp = dat(16'h11); exp[31:0] = 32'hCCCC_DDDD;
    #1;
    tests++; if (wb_valid !== 1'b1 || wb_tag !== 16'h11 || wb_data !== exp) begin fails++; $display("FAIL stall_wb v=%b tag=%h data=%h want 1,0011,%h", wb_valid, wb_tag, wb_data, exp); end
    tests++; if (count !== 3'd4 || rd_hit[0] !== 1'b1) begin fails++; $display("FAIL stall_insert cnt=%0d hit=%b want 4,1", count, rd_hit[0]); end
  endtask

  task automatic test_promote_compact();
    apply_reset();
    #1;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_discard_wb got=%b want=0", wb_valid); end
    for (int t = 16'h10; t <= 16'h12; t++) do_insert(16'(t), 1'b0);
    set_idle(); promote_valid = 1'b1; promote_tag = 16'h11;
    insert_valid = 1'b1; insert_tag = 16'h15; insert_data = dat(16'h15);
    #1;
    tests++; if (promote_hit !== 1'b1 || promote_data !== dat(16'h11) || promote_dirty !== 1'b0) begin fails++; $display("FAIL prom_out hit=%b data=%h dirty=%b want 1,%h,0", promote_hit, promote_data, promote_dirty, dat(16'h11)); end
    tick();
    set_idle(); rd_valid = 2'b11; rd_tag = {16'h10, 16'h11};
    #1;
    tests++; if (count !== 3'd3 || rd_hit !== 2'b10) begin fails++; $display("FAIL prom_remove cnt=%0d hit=%b want 3,10", count, rd_hit); end
    do_insert(16'h16, 1'b0);
    do_insert(16'h17, 1'b0);
    do_insert(16'h18, 1'b0);
    set_idle(); rd_valid = 2'b11; rd_tag = {16'h12, 16'h10};
    #1;
    tests++; if (rd_hit !== 2'b00) begin fails++; $display("FAIL prom_order_old hit=%b want 00", rd_hit); end
    rd_tag = {16'h16, 16'h15};
    #1;
    tests++; if (rd_hit !== 2'b11 || count !== 3'd4 || wb_valid !== 1'b0) begin fails++; $display("FAIL prom_order_young hit=%b cnt=%0d wbv=%b want 11,4,0", rd_hit, count, wb_valid); end
  endtask

  task automatic test_store_promote();
    logic [63:0] exp;
    exp = dat(16'h12); exp[7:0] = 8'hAB;
    apply_reset();
    do_insert(16'h12, 1'b0);
    set_idle(); store_valid = 1'b1; store_tag = 16'h12; store_data = 64'hAB; store_mask = 8'h01;
    rd_valid = 2'b01; rd_tag[15:0] = 16'h12;
    #1;
    tests++; if (rd_data[63:0] !== dat(16'h12)) begin fails++; $display("FAIL store_pre_data got=%h want=%h", rd_data[63:0], dat(16'h12)); end
    tick();
    set_idle(); promote_valid = 1'b1; promote_tag = 16'h12;
    #1;
    tests++; if (promote_hit !== 1'b1 || promote_dirty !== 1'b1 || promote_data !== exp) begin fails++; $display("FAIL store_then_promote hit=%b dirty=%b data=%h want 1,1,%h", promote_hit, promote_dirty, promote_data, exp); end
    tick();
    do_insert(16'h12, 1'b0);
    set_idle(); store_valid = 1'b1; store_tag = 16'h12; store_data = 64'hAB; store_mask = 8'h01;
    promote_valid = 1'b1; promote_tag = 16'h12;
    #1;
    tests++; if (promote_hit !== 1'b1 || promote_dirty !== 1'b1 || promote_data !== exp) begin fails++; $display("FAIL store_promote_same hit=%b dirty=%b data=%h want 1,1,%h", promote_hit, promote_dirty, promote_data, exp); end
    tick();
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL store_promote_count got=%0d want=0", count); end
  endtask

  task automatic test_eager();
    apply_reset();
    do_insert(16'h20, 1'b1);
    set_idle();
    tick();
    rd_valid = 2'b01; rd_tag[15:0] = 16'h20;
    #1;
`ifdef DCACHE_VB_EAGER_DRAIN_EN
    tests++; if (wb_valid !== 1'b1 || wb_tag !== 16'h20 || count !== 3'd1 || rd_hit[0] !== 1'b1) begin fails++; $display("FAIL eager_drain v=%b tag=%h cnt=%0d hit=%b want 1,0020,1,1", wb_valid, wb_tag, count, rd_hit[0]); end
    promote_valid = 1'b1; promote_tag = 16'h20;
    #1;
    tests++; if (promote_hit !== 1'b1 || promote_dirty !== 1'b0) begin fails++; $display("FAIL eager_clean hit=%b dirty=%b want 1,0", promote_hit, promote_dirty); end
`else
    tests++; if (wb_valid !== 1'b0 || count !== 3'd1 || rd_hit[0] !== 1'b1) begin fails++; $display("FAIL no_drain v=%b cnt=%0d hit=%b want 0,1,1", wb_valid, count, rd_hit[0]); end
    promote_valid = 1'b1; promote_tag = 16'h20;
    #1;
    tests++; if (promote_hit !== 1'b1 || promote_dirty !== 1'b1) begin fails++; $display("FAIL no_drain_dirty hit=%b dirty=%b want 1,1", promote_hit, promote_dirty); end
`endif
    tick();
  endtask

  function automatic logic [15:0] pick_tag();
    int k;
    k = int'($urandom_range(9));
    if (k < 6 && mq.size() > 0) return mq[$urandom_range(mq.size() - 1)].tag;
    if (k < 8 && m_wbv) return m_wbt;
    return 16'hF000 | 16'($urandom_range(255));
  endfunction

  task automatic test_random();
    logic [15:0] fresh;
    logic hold;
    fresh = 16'h0100;
    hold = 1'b0;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        insert_valid = ($urandom_range(99) < 50);
        insert_tag = fresh;
        insert_data = {$urandom(), $urandom()};
        insert_dirty = 1'($urandom_range(1));
      end
      rd_valid = 2'($urandom_range(3));
      rd_tag = {pick_tag(), pick_tag()};
      store_valid = ($urandom_range(99) < 30);
      store_tag = pick_tag();
      store_data = {$urandom(), $urandom()};
      store_mask = 8'($urandom_range(255));
      promote_valid = ($urandom_range(99) < 20);
      promote_tag = pick_tag();
      wb_ready = ($urandom_range(99) < 40);
      #1;
      model_comb();
      tests++; if (insert_ready !== e_ready) begin fails++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, insert_ready, e_ready); end
      tests++; if (promote_hit !== e_ph || (e_ph && (promote_data !== e_pd || promote_dirty !== e_pdirty))) begin fails++; $display("FAIL rand_promote cyc=%0d hit=%b data=%h dirty=%b want %b,%h,%b", c, promote_hit, promote_data, promote_dirty, e_ph, e_pd, e_pdirty); end
      for (int r = 0; r < 2; r++) begin
        tests++; if (rd_hit[r] !== e_rd_hit[r] || rd_data[64*r +: 64] !== e_rd_data[r]) begin fails++; $display("FAIL rand_lookup cyc=%0d port=%0d hit=%b data=%h want %b,%h", c, r, rd_hit[r], rd_data[64*r +: 64], e_rd_hit[r], e_rd_data[r]); end
      end
      tests++; if (count !== 3'(mq.size())) begin fails++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", c, count, mq.size()); end
      tests++; if (wb_valid !== m_wbv || (m_wbv && (wb_tag !== m_wbt || wb_data !== m_wbd))) begin fails++; $display("FAIL rand_wb cyc=%0d v=%b tag=%h data=%h want %b,%h,%h", c, wb_valid, wb_tag, wb_data, m_wbv, m_wbt, m_wbd); end
      hold = insert_valid && !e_ready;
      if (insert_valid && e_ready) fresh = fresh + 16'h1;
      tick();
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    m_wbv = 1'b0; m_wbt = '0; m_wbd = '0;
    test_reset();
    test_fill();
`ifndef DCACHE_VB_EAGER_DRAIN_EN
    test_dirty_displace();
    test_stall();
`endif
    test_promote_compact();
`ifndef DCACHE_VB_EAGER_DRAIN_EN
    test_store_promote();
`endif
    test_eager();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
